dma_copy_engine: RTL

Word-granular DMA engine sitting directly upstream of the shared RAM arbiter and memory module. It accepts a block-copy command (source, destination, length), requests the RAM port from the arbiter, and moves each 10-bit word with one read followed by one write. It raises `done` when the last word is written. It is the producer behind the DMA requester of the arbiter and the source of the `D_DMASTATE`, `D_DMAADDR` and `D_DMADATA` debug taps.

---
 rtl/mp_pkg.sv | 15 +
 rtl/dma_copy_engine.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mp_pkg.sv
// Shared memory-path package: RAM geometry and the DMA state encoding
// used by the engine, the arbiter and the debug mux.
package mp_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } dma_state_t;

endpackage

// File: rtl/dma_copy_engine.sv
// Word-granular block copy engine in front of the RAM arbiter.
// Optional DMA_FILL_EN adds a constant-fill mode that skips the read.
module dma_copy_engine #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 10,
  parameter int LEN_W  = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
`ifdef DMA_FILL_EN
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_data,
`endif
  output logic              busy,
  output logic              done,
  output logic              req,
  input  logic              grant,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_read,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        dma_state,
  output logic [DATA_W-1:0] dma_data
);

  import mp_pkg::*;

  dma_state_t        state, state_n;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  len_q, cnt;
  logic [DATA_W-1:0] data_q;
  logic              done_q;
  logic              last;
  logic              fill_mode;
  logic [DATA_W-1:0] wsrc;

`ifdef DMA_FILL_EN
  logic              fill_q;
  logic [DATA_W-1:0] fill_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q      <= 1'b0;
      fill_data_q <= '0;
    end else if (state == IDLE && start) begin
      fill_q      <= fill;
      fill_data_q <= fill_data;
    end
  end

  assign fill_mode = fill_q;
  assign wsrc      = fill_q ? fill_data_q : ram_rdata;
`else
  assign fill_mode = 1'b0;
  assign wsrc      = ram_rdata;
`endif

  assign last = (cnt + LEN_W'(1)) == len_q;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start && len != '0) state_n = REQ;
      REQ:   if (grant) state_n = fill_mode ? WRITE : READ;
      READ:  state_n = WRITE;
      WRITE: state_n = last ? IDLE : REQ;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      cnt    <= '0;
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= (state == IDLE && start && len == '0)
             || (state == WRITE && last);
      if (state == IDLE && start) begin
        src_q <= src_addr;
        dst_q <= dst_addr;
        len_q <= len;
        cnt   <= '0;
      end
      if (state == WRITE) begin
        data_q <= wsrc;
        if (!last) cnt <= cnt + LEN_W'(1);
      end
    end
  end

  // Everything below decodes registered state; only wdata passes rdata through.
  always_comb begin
    ram_addr = '0;
    unique case (state)
      READ:    ram_addr = src_q + ADDR_W'(cnt);
      WRITE:   ram_addr = dst_q + ADDR_W'(cnt);
      default: ram_addr = '0;
    endcase
  end

  assign busy      = state != IDLE;
  assign req       = state != IDLE;
  assign ram_read  = state == READ;
  assign ram_write = state == WRITE;
  assign ram_wdata = (state == WRITE) ? wsrc : '0;
  assign done      = done_q;
  assign dma_state = state;
  assign dma_data  = data_q;

endmodule
